fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end. It replaces the single-register PC/PC+4 scheme with a decoupled fetch unit.
- It generates sequential fetch addresses and issues them over a valid/ready request channel. It keeps several requests in flight and buffers in-order responses in a DEPTH-entry ring together with their PCs.
- It delivers {instr, instr_pc} to decode over a valid/ready channel and flushes cleanly on a branch/jump redirect.

---
 rtl/fetch_queue.sv | 209 ++++++++++++++++++++
 tb/tb_fetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled fetch front end. Issues sequential word fetches
// over a valid/ready request channel and keeps up to DEPTH requests in
// flight. In-order responses are buffered in a DEPTH-entry ring with their
// PCs and handed to decode over a valid/ready channel. A redirect flushes
// the ring, restarts fetch at the new target and arms a drop counter that
// discards responses still owed to pre-redirect requests.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   imem_req_*          fetch request: valid/ready, word-aligned addr
//   imem_rsp_*          in-order response: valid, 32-bit data
//   redirect_*          flush strobe and new fetch target
//   instr_*             decode channel: valid/ready, instr word and PC
//   perf_redirects      redirect count (FETCH_PERF_EN)
//   perf_starve         cycles without instr_valid (FETCH_PERF_EN)
//
// Build option: define FETCH_PERF_EN to add the two performance counters;
// otherwise both perf ports read 0 and no counter flops exist.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_starve
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;

  logic [PW-1:0] alloc_q;
  logic [PW-1:0] alloc_d;
  logic [PW-1:0] fill_q;
  logic [PW-1:0] fill_d;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] rd_d;
  logic [PW-1:0] drop_q;
  logic [PW-1:0] drop_d;

  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [XLEN-1:0]  pc_d     [DEPTH];
  logic [31:0]      data_q   [DEPTH];
  logic [31:0]      data_d   [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [DEPTH-1:0] filled_d;

  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] rd_idx;

  logic [PW-1:0] occ;
  logic [PW-1:0] inflight;
  logic [PW:0]   credit;
  logic [PW:0]   outstanding;

  logic req_fire;
  logic rsp_drop;
  logic rsp_fill;
  logic deq;

  logic unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  assign alloc_idx = alloc_q[AW-1:0];
  assign fill_idx  = fill_q[AW-1:0];
  assign rd_idx    = rd_q[AW-1:0];

  // occ: ring slots held; inflight: accepted but not yet answered.
  // Stale responses still owed (drop_q) also consume request credit.
  assign occ         = alloc_q - rd_q;
  assign inflight    = alloc_q - fill_q;
  assign credit      = {1'b0, occ} + {1'b0, drop_q};
  assign outstanding = {1'b0, inflight} + {1'b0, drop_q};

  assign imem_req_valid = !rst && (credit < (PW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign instr_valid = filled_q[rd_idx]
                    && (rd_q != alloc_q)
                    && !redirect_valid;
  assign instr       = data_q[rd_idx];
  assign instr_pc    = pc_q[rd_idx];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_fill = imem_rsp_valid && (drop_q == '0);
  assign deq      = instr_valid && instr_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    rd_d       = rd_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    data_d     = data_q;
    filled_d   = filled_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      // Every request not yet answered becomes stale, including one
      // accepted this cycle. A response arriving now is itself stale:
      // it either retires a pending drop or answers one of the
      // inflight requests, so either way one fewer is still owed.
      drop_d     = drop_q + inflight
                 + PW'(req_fire)
                 - PW'(imem_rsp_valid);
      alloc_d    = alloc_q + PW'(req_fire);
      fill_d     = alloc_d;
      rd_d       = alloc_d;
      filled_d   = '0;
    end else begin
      if (req_fire) begin
        pc_d[alloc_idx]     = fetch_pc_q;
        filled_d[alloc_idx] = 1'b0;
        alloc_d             = alloc_q + PW'(1);
        fetch_pc_d          = fetch_pc_q + XLEN'(4);
      end
      if (rsp_drop) begin
        drop_d = drop_q - PW'(1);
      end
      if (rsp_fill) begin
        data_d[fill_idx]   = imem_rsp_data;
        filled_d[fill_idx] = 1'b1;
        fill_d             = fill_q + PW'(1);
      end
      if (deq) begin
        filled_d[rd_idx] = 1'b0;
        rd_d             = rd_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      alloc_q    <= '0;
      fill_q     <= '0;
      rd_q       <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      rd_q       <= rd_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
      pc_q       <= pc_d;
      data_q     <= data_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects_q;
  logic [31:0] perf_redirects_d;
  logic [31:0] perf_starve_q;
  logic [31:0] perf_starve_d;

  always_comb begin
    perf_redirects_d = perf_redirects_q + 32'(redirect_valid);
    perf_starve_d    = perf_starve_q + 32'(!instr_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_redirects_q <= '0;
      perf_starve_q    <= '0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_starve_q    <= perf_starve_d;
    end
  end

  assign perf_redirects = perf_redirects_q;
  assign perf_starve    = perf_starve_q;
`else
  assign perf_redirects = '0;
  assign perf_starve    = '0;
`endif

  // A response with nothing owed means the memory broke ordering.
  rsp_has_owner: assert property (
    @(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed table-driven bench for fetch_queue with an
// in-order memory responder (1-cycle latency, stallable by hold).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] perf_redirects;
  logic [31:0] perf_starve;
  logic        hold = 1'b0;

  int nchk = 0;
  int nerr = 0;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC('0)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .perf_redirects(perf_redirects),
    .perf_starve(perf_starve)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  // Memory: answers accepted requests in order, next cycle at earliest.
  logic [31:0] mq[$];
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready)
        mq.push_back(imem_req_addr);
      if (!hold && mq.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(mq.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  typedef struct {
    bit          rs;
    bit          ir;
    bit          rr;
    bit          hd;
    bit          rd;
    logic [31:0] rpc;
    bit          rv;
    logic [31:0] ad;
    bit          iv;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit rs, input bit ir, input bit rr,
                     input bit hd, input bit rd,
                     input logic [31:0] rpc,
                     input bit rv, input logic [31:0] ad,
                     input bit iv, input logic [31:0] pc);
    vec_t v;
    v.rs = rs; v.ir = ir; v.rr = rr; v.hd = hd; v.rd = rd;
    v.rpc = rpc; v.rv = rv; v.ad = ad; v.iv = iv; v.pc = pc;
    tv.push_back(v);
  endtask

  task automatic add_rst();
    add(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    // streaming, single-cycle memory, decode always ready
    add_rst();
    add(0,1,1,0,0,0, 1,32'h00,0,0);
    add(0,1,1,0,0,0, 1,32'h04,0,0);
    add(0,1,1,0,0,0, 1,32'h08,1,32'h00);
    add(0,1,1,0,0,0, 1,32'h0C,1,32'h04);
    add(0,1,1,0,0,0, 1,32'h10,1,32'h08);
    add(0,1,1,0,0,0, 1,32'h14,1,32'h0C);
    // decode stalled: ring fills, then drains in order
    add_rst();
    add(0,0,1,0,0,0, 1,32'h00,0,0);
    add(0,0,1,0,0,0, 1,32'h04,0,0);
    add(0,0,1,0,0,0, 1,32'h08,1,32'h00);
    add(0,0,1,0,0,0, 1,32'h0C,1,32'h00);
    add(0,0,1,0,0,0, 0,32'h10,1,32'h00);
    add(0,1,1,0,0,0, 0,32'h10,1,32'h00);
    add(0,1,1,0,0,0, 1,32'h10,1,32'h04);
    add(0,1,1,0,0,0, 1,32'h14,1,32'h08);
    add(0,1,1,0,0,0, 1,32'h18,1,32'h0C);
    add(0,1,1,0,0,0, 1,32'h1C,1,32'h10);
    // request stall, redirect (misaligned) during the stall
    add_rst();
    add(0,1,0,0,0,0, 1,32'h00,0,0);
    add(0,1,0,0,0,0, 1,32'h00,0,0);
    add(0,1,0,0,0,0, 1,32'h00,0,0);
    add(0,1,0,0,0,0, 1,32'h00,0,0);
    add(0,1,0,0,0,0, 1,32'h00,0,0);
    add(0,1,0,0,1,32'h41, 1,32'h00,0,0);
    add(0,1,1,0,0,0, 1,32'h40,0,0);
    add(0,1,1,0,0,0, 1,32'h44,0,0);
    add(0,1,1,0,0,0, 1,32'h48,1,32'h40);
    // redirect with 3 outstanding, memory held
    add_rst();
    add(0,1,1,1,0,0, 1,32'h00,0,0);
    add(0,1,1,1,0,0, 1,32'h04,0,0);
    add(0,1,1,1,0,0, 1,32'h08,0,0);
    add(0,1,0,1,1,32'h103, 1,32'h0C,0,0);
    add(0,1,1,0,0,0, 1,32'h100,0,0);
    add(0,1,1,0,0,0, 0,32'h104,0,0);
    add(0,1,1,0,0,0, 1,32'h104,0,0);
    add(0,1,1,0,0,0, 1,32'h108,0,0);
    add(0,1,1,0,0,0, 1,32'h10C,0,0);
    add(0,1,1,0,0,0, 0,32'h110,1,32'h100);
    add(0,1,1,0,0,0, 1,32'h110,1,32'h104);
    // back-to-back redirects, handshake in the second one
    add_rst();
    add(0,1,1,1,0,0, 1,32'h00,0,0);
    add(0,1,1,1,0,0, 1,32'h04,0,0);
    add(0,1,0,1,1,32'h200, 1,32'h08,0,0);
    add(0,1,1,1,1,32'h300, 1,32'h200,0,0);
    add(0,1,1,0,0,0, 1,32'h300,0,0);
    add(0,1,1,0,0,0, 0,32'h304,0,0);
    add(0,1,1,0,0,0, 1,32'h304,0,0);
    add(0,1,1,0,0,0, 1,32'h308,0,0);
    add(0,1,1,0,0,0, 1,32'h30C,0,0);
    add(0,1,1,0,0,0, 0,32'h310,1,32'h300);
    // async reset mid-stream with 3 entries filled
    add_rst();
    add(0,0,1,0,0,0, 1,32'h00,0,0);
    add(0,0,1,0,0,0, 1,32'h04,0,0);
    add(0,0,1,0,0,0, 1,32'h08,1,32'h00);
    add(0,0,1,0,0,0, 1,32'h0C,1,32'h00);
    add(0,0,1,0,0,0, 0,32'h10,1,32'h00);
    add_rst();
    add(0,1,1,0,0,0, 1,32'h00,0,0);
    add(0,1,1,0,0,0, 1,32'h04,0,0);
    add(0,1,1,0,0,0, 1,32'h08,1,32'h00);

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      rst            = tv[i].rs;
      instr_ready    = tv[i].ir;
      imem_req_ready = tv[i].rr;
      hold           = tv[i].hd;
      redirect_valid = tv[i].rd;
      redirect_pc    = tv[i].rpc;
      #1;
      chk($sformatf("v%0d req_valid", i),
          {31'b0, imem_req_valid}, {31'b0, tv[i].rv});
      chk($sformatf("v%0d req_addr", i), imem_req_addr, tv[i].ad);
      chk($sformatf("v%0d instr_valid", i),
          {31'b0, instr_valid}, {31'b0, tv[i].iv});
      if (tv[i].rs) begin
        chk($sformatf("v%0d rst instr", i), instr, 32'h0);
        chk($sformatf("v%0d rst instr_pc", i), instr_pc, 32'h0);
      end else if (tv[i].iv) begin
        chk($sformatf("v%0d instr_pc", i), instr_pc, tv[i].pc);
        chk($sformatf("v%0d instr", i), instr, mem_word(tv[i].pc));
      end
      @(negedge clk);
    end

    // performance counters: reset, then two consecutive redirects
    rst            = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("perf_redirects rst", perf_redirects, 32'd0);
    chk("perf_starve rst", perf_starve, 32'd0);
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    @(negedge clk);
    redirect_pc    = 32'h600;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("redirect addr", imem_req_addr, 32'h600);
`ifdef FETCH_PERF_EN
    chk("perf_redirects", perf_redirects, 32'd2);
    chk("perf_starve", perf_starve, 32'd2);
`else
    chk("perf_redirects off", perf_redirects, 32'd0);
    chk("perf_starve off", perf_starve, 32'd0);
`endif
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
